// File: rtl/mult_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_acc_seq
// Description : Sequential unsigned multiplier with an optional accumulator.
//               Each operand is split into base-4 digits. One 2x2 digit
//               product is shifted into place and added to a partial sum on
//               every CALC cycle, so a full product takes (WIDTH/2)^2 cycles.
//               On completion the product is published and, in accumulate
//               mode, added into a wrapping accumulator with a sticky carry
//               flag.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start_i         - begin an operation (sampled in IDLE only)
//               mode_i          - 0: multiply, 1: multiply and accumulate
//               clr_i           - clear acc_o/ovf_o (honoured in IDLE only)
//               a_i, b_i        - unsigned operands, latched with start_i
//               busy_o          - high in CALC and DONE
//               done_o          - one-cycle pulse when results update
//               product_o       - last completed product
//               acc_o, ovf_o    - running accumulator and sticky carry flag
// Revision    : 1.0 - initial release
// ============================================================================
module mult_acc_seq #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 clr_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [ACC_W-1:0]     acc_o,
    output logic                 ovf_o
);

    localparam int c_N     = WIDTH / 2;
    // A single-digit operand still needs a 1-bit index register.
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);
    localparam logic [c_IDX_W-1:0] c_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 mode_q, mode_d;
    logic [2*WIDTH-1:0]   psum_q, psum_d;
    logic [c_IDX_W-1:0]   i_q, i_d;
    logic [c_IDX_W-1:0]   j_q, j_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    // Datapath for the current digit pair.
    logic [1:0]           w_a_dig;
    logic [1:0]           w_b_dig;
    logic [3:0]           w_dp;
    logic [c_IDX_W:0]     w_shift;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_psum_next;
    logic [ACC_W:0]       w_acc_sum;
    logic                 w_last;

    assign w_a_dig     = a_q[{i_q, 1'b0} +: 2];
    assign w_b_dig     = b_q[{j_q, 1'b0} +: 2];
    assign w_dp        = {2'b00, w_a_dig} * {2'b00, w_b_dig};
    assign w_shift     = {1'b0, i_q} + {1'b0, j_q};
    // Digit weight is 4^(i+j), i.e. a left shift of 2*(i+j).
    assign w_pp        = (2*WIDTH)'(w_dp) << {w_shift, 1'b0};
    // Sum of all digit products equals a*b, which fits 2*WIDTH bits exactly.
    assign w_psum_next = psum_q + w_pp;
    // Extra top bit captures the accumulator carry-out.
    assign w_acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(w_psum_next);
    assign w_last      = (i_q == c_LAST) && (j_q == c_LAST);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        psum_d    = psum_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = mode_i;
                    psum_d  = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                psum_d = w_psum_next;
                if (j_q == c_LAST) begin
                    j_d = '0;
                    i_d = (i_q == c_LAST) ? '0 : i_q + c_ONE;
                end else begin
                    j_d = j_q + c_ONE;
                end
                // Results are published on the same edge that adds the final
                // digit product, so they are visible during the DONE cycle.
                if (w_last) begin
                    state_d   = S_DONE;
                    product_d = w_psum_next;
                    if (mode_q) begin
                        acc_d = w_acc_sum[ACC_W-1:0];
                        ovf_d = ovf_q | w_acc_sum[ACC_W];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            psum_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            psum_q    <= psum_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;
    assign acc_o     = acc_q;
    assign ovf_o     = ovf_q;

endmodule
`default_nettype wire

// File: doc/mult_acc_seq.md
MULT_ACC_SEQ -- requirements
Module: mult_acc_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be even and >= 2.
REQ-002 Parameter ACC_W, default 20, accumulator width; SHALL be >= 2*WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request new operation; sampled only in IDLE.
REQ-006 mode  input  1  0 = multiply only, 1 = multiply and add product into acc; latched with start.
REQ-007 clr  input  1  clear acc and ovf; honoured only in IDLE.
REQ-008 a  input  WIDTH  unsigned multiplicand; latched with start.
REQ-009 b  input  WIDTH  unsigned multiplier; latched with start.
REQ-010 busy  output  1  high in CALC and DONE states.
REQ-011 done  output  1  one-cycle pulse when product (and acc) updated.
REQ-012 product  output  2*WIDTH  last completed unsigned product.
REQ-013 acc  output  ACC_W  running accumulator.
REQ-014 ovf  output  1  sticky accumulator carry-out flag.

Function
REQ-015 FSM SHALL have states IDLE, CALC, DONE; IDLE -> CALC on start; CALC -> DONE after last digit pair; DONE -> IDLE unconditionally.
REQ-016 N = WIDTH/2 base-4 digits per operand; a_i = a[2i+1:2i], b_j = b[2j+1:2j].
REQ-017 On start in IDLE: latch a, b, mode; clear internal partial sum; digit indices i = j = 0.
REQ-018 Each CALC cycle SHALL add exactly one 4-bit 2x2 digit product (a_i*b_j) shifted left 2*(i+j) into the 2*WIDTH-bit partial sum; no other multiplier allowed.
REQ-019 Index order: j increments each cycle; on j = N-1, j wraps to 0 and i increments; CALC lasts exactly N*N cycles.
REQ-020 Partial sum SHALL never overflow 2*WIDTH bits (exact product).
REQ-021 On entry to DONE: product <= partial sum; if latched mode = 1, acc <= (acc + zero-extended product) mod 2^ACC_W, ovf <= ovf | carry-out; if mode = 0, acc and ovf unchanged.
REQ-022 done SHALL be high for exactly the DONE cycle; product/acc show new values in that same cycle and hold until next DONE, clr or rst.
REQ-023 Latency: done asserts N*N+1 cycles after the cycle in which start was sampled high (17 for WIDTH=8); throughput one op per N*N+2 cycles.
REQ-024 start while busy SHALL be ignored, not queued; latched a, b, mode unaffected by input changes during CALC.
REQ-025 clr in IDLE SHALL zero acc and ovf next edge; clr while busy ignored.
REQ-026 clr and start together in IDLE: both honoured; acc cleared, operation begins; a mode=1 op then yields acc = product.
REQ-027 busy SHALL be low only in IDLE.

Reset
REQ-028 rst high at an edge SHALL force IDLE and zero busy, done, product, acc, ovf, partial sum and indices, in any state.
REQ-029 rst mid-CALC or in DONE SHALL abort: no done pulse, no acc update for that operation.
REQ-030 rst has priority over start and clr.

Verification
REQ-031 rst 2 cycles -> busy=0, done=0, product=0, acc=0, ovf=0.
REQ-032 WIDTH=8: a=1, b=3, mode=0 -> done 17 cycles after start, product=3, acc=0; then a=3, b=2 -> product=6.
REQ-033 WIDTH=8: a=255, b=255, mode=1 -> product=65025, acc=65025, ovf=0.
REQ-034 WIDTH=8, ACC_W=16: two mode=1 ops 255*255 -> acc=64514, ovf=1; then clr in IDLE -> acc=0, ovf=0.
REQ-035 start pulsed during CALC with new operands -> ignored, single done, product of original operands; clr+start same IDLE cycle, a=2, b=2, mode=1 -> acc=4.
REQ-036 rst asserted 5 cycles into CALC -> busy=0 next cycle, no done, acc unchanged from 0, next start completes normally.
